// File: rtl/custom_exec_unit.sv
// custom_exec_unit
//   Execute stage for the custom opcode. Runs a multi-cycle signed int8
//   packed dot product (MATMUL, alu_ctrl=110) or a single-cycle ReLU
//   (alu_ctrl=111) and holds the core with stall until writeback.
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   custom_en  decoded custom instruction present
//   alu_ctrl   operation select (110 MATMUL, 111 RELU, others ignored)
//   rs1_data   operand A
//   rs2_data   operand B
//   busy       MATMUL accumulation in progress
//   done       one-cycle pulse, result valid for writeback
//   stall      freeze PC/fetch (combinational)
//   result     last completed result, held until next completion
//
// Build option
//   CUSTOM_SAT_EN  clamp the MATMUL result to signed 16-bit, sign-extended.
//
// State table
//   IDLE | waiting for a request; only state that accepts one
//   MAC  | one lane multiply-accumulate per cycle, lane 0 first
//   FIN  | result written, done pulses; returns to IDLE unconditionally
module custom_exec_unit #(
  parameter int DATA_W = 32,
  parameter int ELEM_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              custom_en,
  input  logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic [DATA_W-1:0] result
);

  localparam int N_ELEM = DATA_W / ELEM_W;
  localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);
  localparam logic [2:0] OP_MATMUL = 3'b110;
  localparam logic [2:0] OP_RELU   = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, FIN = 2'd2} state_t;

  state_t state, state_nxt;
  logic signed [DATA_W-1:0] acc, acc_nxt, acc_sum;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] a_q, b_q, a_nxt, b_nxt, result_nxt;
  logic is_matmul, is_relu;

  logic signed [ELEM_W-1:0]   a_lane [N_ELEM];
  logic signed [ELEM_W-1:0]   b_lane [N_ELEM];
  logic signed [2*ELEM_W-1:0] prod;

  assign is_matmul = custom_en && (alu_ctrl == OP_MATMUL);
  assign is_relu   = custom_en && (alu_ctrl == OP_RELU);

  // Drops in the done cycle so writeback and PC advance coincide.
  assign stall = (is_matmul || is_relu) && !done;

  always_comb begin
    for (int i = 0; i < N_ELEM; i++) begin
      a_lane[i] = a_q[i*ELEM_W +: ELEM_W];
      b_lane[i] = b_q[i*ELEM_W +: ELEM_W];
    end
  end

  assign prod    = a_lane[idx] * b_lane[idx];
  assign acc_sum = acc + {{(DATA_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};

  function automatic logic [DATA_W-1:0] finish_matmul(input logic signed [DATA_W-1:0] v);
`ifdef CUSTOM_SAT_EN
    logic signed [DATA_W-1:0] sat_max;
    logic signed [DATA_W-1:0] sat_min;
    sat_max = DATA_W'(32767);
    sat_min = ~sat_max;
    if (v > sat_max)      finish_matmul = sat_max;
    else if (v < sat_min) finish_matmul = sat_min;
    else                  finish_matmul = v;
`else
    finish_matmul = v;
`endif
  endfunction

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    idx_nxt    = idx;
    a_nxt      = a_q;
    b_nxt      = b_q;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (is_matmul) begin
          state_nxt = MAC;
          acc_nxt   = '0;
          idx_nxt   = '0;
          a_nxt     = rs1_data;
          b_nxt     = rs2_data;
        end else if (is_relu) begin
          state_nxt  = FIN;
          a_nxt      = rs1_data;
          b_nxt      = rs2_data;
          result_nxt = rs1_data[DATA_W-1] ? '0 : rs1_data;
        end
      end
      MAC: begin
        acc_nxt = acc_sum;
        idx_nxt = idx + IDX_W'(1);
        if (idx == IDX_LAST) begin
          state_nxt  = FIN;
          // Clamping (if built in) applies to the written result only.
          result_nxt = finish_matmul(acc_sum);
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      idx    <= idx_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      result <= result_nxt;
      busy   <= (state_nxt == MAC);
      done   <= (state_nxt == FIN);
    end
  end

endmodule

// File: tb/tb_custom_exec_unit.sv
module tb_custom_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        custom_en;
  logic [2:0]  alu_ctrl;
  logic [31:0] rs1_data, rs2_data;
  logic        busy, done, stall;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc_now = 0;
  int t_first, t_second;
  int done_seen;
  logic [31:0] held;

  custom_exec_unit #(.DATA_W(32), .ELEM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .custom_en(custom_en), .alu_ctrl(alu_ctrl),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy), .done(done), .stall(stall), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and follow it up to its done cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl,
                       input logic [31:0] exp_res, input int exp_lat, input int exp_busy,
                       input bit scramble, output int done_at);
    int n, busy_cnt, stall_cnt;
    bit got;
    custom_en = 1'b1; alu_ctrl = ctrl; rs1_data = a; rs2_data = b;
    #1;
    chk("req_stall", stall, 1);
    chk("req_idle_busy", busy, 0);
    n = 0; busy_cnt = 0; stall_cnt = 0; got = 0; done_at = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (scramble) begin
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      #1;
      if (done) begin
        got = 1;
        done_at = cyc_now;
      end else begin
        if (busy)  busy_cnt++;
        if (stall) stall_cnt++;
      end
    end
    chk("done_seen", got, 1);
    chk("done_latency", n, exp_lat);
    chk("result", result, exp_res);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("stall_cycles", stall_cnt, exp_lat - 1);
    chk("stall_in_done", stall, 0);
    chk("busy_in_done", busy, 0);
  endtask

  task automatic idle_after(input logic [31:0] exp_res);
    custom_en = 1'b0;
    tick();
    chk("done_pulse_ends", done, 0);
    chk("result_held", result, exp_res);
  endtask

  initial begin
    int d;
    rst_n = 1'b0; custom_en = 1'b1; alu_ctrl = 3'b110;
    rs1_data = 32'h04030201; rs2_data = 32'h08070605;

    // Reset held with a request present: nothing advances.
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    tick();
    chk("rst_busy2", busy, 0);
    chk("rst_done2", done, 0);
    rst_n = 1'b1;

    // MATMUL basic: 1*5 + 2*6 + 3*7 + 4*8 = 70.
    do_op(32'h04030201, 32'h08070605, 3'b110, 32'h00000046, 5, 4, 0, d);
    idle_after(32'h00000046);

    // Signed: -1 * 2 over four lanes.
    do_op(32'hFFFFFFFF, 32'h02020202, 3'b110, 32'hFFFFFFF8, 5, 4, 0, d);
    idle_after(32'hFFFFFFF8);

    // (-128)^2 * 4 = 65536, clamped to 32767 when saturation is built in.
`ifdef CUSTOM_SAT_EN
    do_op(32'h80808080, 32'h80808080, 3'b110, 32'h00007FFF, 5, 4, 0, d);
    idle_after(32'h00007FFF);
`else
    do_op(32'h80808080, 32'h80808080, 3'b110, 32'h00010000, 5, 4, 0, d);
    idle_after(32'h00010000);
`endif

    // RELU negative then positive.
    do_op(32'h80000001, 32'h0, 3'b111, 32'h00000000, 1, 0, 0, d);
    idle_after(32'h00000000);
    do_op(32'h7FFFFFFF, 32'h0, 3'b111, 32'h7FFFFFFF, 1, 0, 0, d);
    idle_after(32'h7FFFFFFF);

    // Operands scrambled during MAC: 15 - 4 + 128 + 381 = 520.
    do_op(32'h7F80FE03, 32'h03FF0205, 3'b110, 32'h00000208, 5, 4, 1, d);
    idle_after(32'h00000208);

    // Unsupported alu_ctrl: no stall, no acceptance.
    custom_en = 1'b1; alu_ctrl = 3'b000;
    #1;
    chk("unsup_stall", stall, 0);
    tick(); tick(); tick();
    chk("unsup_busy", busy, 0);
    chk("unsup_done", done, 0);
    chk("unsup_result", result, 32'h00000208);

    // Back-to-back MATMULs, request kept high through FIN.
    do_op(32'h04030201, 32'h08070605, 3'b110, 32'h00000046, 5, 4, 0, t_first);
    tick();
    chk("b2b_fin_no_reaccept_done", done, 0);
    chk("b2b_fin_no_reaccept_busy", busy, 0);
    do_op(32'h01010101, 32'h01010101, 3'b110, 32'h00000004, 5, 4, 0, t_second);
    chk("b2b_spacing", t_second - t_first, 6);
    idle_after(32'h00000004);

    // Reset in the second MAC cycle abandons the operation.
    custom_en = 1'b1; alu_ctrl = 3'b110;
    rs1_data = 32'h04030201; rs2_data = 32'h08070605;
    tick();
    chk("midrst_mac1_busy", busy, 1);
    tick();
    rst_n = 1'b0; custom_en = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);
    chk("midrst_result_after", result, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
